nibble_serial_subtractor: RTL and testbench
===========================================

# nibble_serial_subtractor

Multi-cycle unsigned subtractor that computes D = A − B one 4-bit nibble per clock, chaining the borrow between nibbles. Each nibble is formed with a 4-bit carry-lookahead stage as A + ~B + ~borrow. It is the inverse-operation companion to the Lab5 lookahead adder datapath and trades latency for a small, fixed-width arithmetic core. It sits behind a start/done handshake and shares the codebase's `enable` stall convention.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; W = 4·NIBBLES; legal values are 1 to 16.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: global advance; when low, all state and outputs freeze.
- `start` input 1: request a new subtraction; sampled only in IDLE with `enable`=1.
- `A` input W: minuend; latched on an accepted start.
- `B` input W: subtrahend; latched on an accepted start.
- `busy` output 1: high in the RUN and DONE states.
- `done` output 1: high only in the DONE state.
- `D` output W: difference; valid from DONE and held until the next accepted start.
- `borrow` output 1: final borrow-out (1 when A < B); valid and held like `D`.
- `zero` output 1: high when D == 0; valid and held like `D`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start`=1 and `enable`=1.
  - Latch A and B into operand registers.
  - Clear the nibble index `idx` to 0.
  - Set the running borrow `br` to 0.
- RUN, each enabled cycle:
  - Compute {c4, s} = A[idx] + ~B[idx] + ~br using the 4-bit lookahead stage.
  - Write s into D[idx].
  - Update br ← ~c4 and idx ← idx + 1.
- RUN → DONE after the enabled cycle with idx == NIBBLES−1.
- DONE → IDLE after one enabled cycle. `borrow` = br and `zero` = (D == 0) are registered on entry to DONE.
- `start` in RUN or DONE is ignored and produces no error.
- When `enable`=0, state, idx, br, operand registers and outputs all hold. A frozen DONE keeps `done`=1.
- Reset values: state = IDLE, idx = 0, br = 0, D = 0, `borrow` = 0, `zero` = 0, `busy` = 0, `done` = 0.
- Reset mid-operation: the operation is abandoned. The next cycle is IDLE with reset values, and no `done` pulse is produced.
- Arithmetic is modulo 2^W, so wrap-around is expected. For example, 0 − 1 gives D = all ones and `borrow` = 1.

## Timing
- Start accepted at edge T. RUN covers edges T+1 … T+NIBBLES. DONE is visible after edge T+NIBBLES, for one cycle when `enable` stays high.
- Latency from start to `done` is NIBBLES+1 cycles, plus any cycles with `enable` low.
- Minimum spacing between accepted starts is NIBBLES+2 cycles.
- Partial D nibbles change during RUN. D is valid only while `done`=1 or later in IDLE.

## Configuration
- `NIBBLE_SUB_SAT_EN`
  - Defined: saturating mode. If the final borrow is 1, D is forced to 0 at DONE and `zero` = 1. `borrow` still reports 1.
  - Undefined: wrapping mode, as described above.

## Structure
- Package `nibble_sub_pkg` holds:
  - `NIB_W` = 4.
  - The state typedef {IDLE, RUN, DONE}.
- Sub-module `sub_nibble_cla`: combinational 4-bit lookahead.
  - Inputs: a[3:0], b[3:0], bin.
  - Outputs: d[3:0], bout.
  - Implementation: explicit generate/propagate terms on a and ~b, with carry-in ~bin.
- Top level holds the FSM, idx counter, operand registers and D register.

## Test plan
All scenarios use NIBBLES=4.
- A=0x1234, B=0x0234, start pulse → after 5 cycles `done`=1, D=0x1000, `borrow`=0, `zero`=0.
- A=0x0000, B=0x0001 → D=0xFFFF, `borrow`=1. With `NIBBLE_SUB_SAT_EN` defined: D=0x0000, `zero`=1, `borrow`=1.
- A=0xA5A5, B=0xA5A5 → D=0x0000, `zero`=1, `borrow`=0. Also check nibble borrow chaining with A=0x1000, B=0x0001 → D=0x0FFF.
- Run 0x1234 − 0x0234 with `enable` held low for 3 cycles during RUN → `done` arrives at cycle 8, D=0x1000; all outputs frozen while stalled.
- Assert `reset` on the third RUN cycle → next cycle IDLE, `busy`=0, D=0, no `done`. A fresh start then completes normally.
- Pulse `start` with new operands while `busy` → ignored. The result still matches the first operands, and `done` pulses exactly once.

Source files
------------

// File: rtl/nibble_sub_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial subtractor.
package nibble_sub_pkg;

  localparam int unsigned NIB_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/sub_nibble_cla.sv
// 4-bit carry-lookahead subtract stage: d = a - b - bin, formed as a + ~b + ~bin.
module sub_nibble_cla
  import nibble_sub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             bin,
  output logic [NIB_W-1:0] d,
  output logic             bout
);

  logic [NIB_W-1:0] bn;
  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  assign bn = ~b;
  assign g  = a & bn;
  assign p  = a ^ bn;
  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d    = p ^ c[NIB_W-1:0];
  // A carry-out of the inverted-operand sum means no borrow.
  assign bout = ~c[NIB_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor, one nibble per enabled clock.
// Define NIBBLE_SUB_SAT_EN for saturating mode (negative results clamp to zero).
module nibble_serial_subtractor
  import nibble_sub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] A,
  input  logic [NIB_W*NIBBLES-1:0] B,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] D,
  output logic                     borrow,
  output logic                     zero
);

  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                        state_q;
  logic [IDX_W-1:0]              idx_q;
  logic                          br_q;
  logic                          borrow_q;
  logic                          zero_q;
  logic [NIBBLES-1:0][NIB_W-1:0] a_q;
  logic [NIBBLES-1:0][NIB_W-1:0] b_q;
  logic [NIBBLES-1:0][NIB_W-1:0] d_q;
  logic [NIBBLES-1:0][NIB_W-1:0] d_upd;
  logic [NIBBLES-1:0][NIB_W-1:0] d_fin;
  logic [NIB_W-1:0]              nib_d;
  logic                          nib_bout;

  sub_nibble_cla u_cla (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .bin  (br_q),
    .d    (nib_d),
    .bout (nib_bout)
  );

  // d_fin is the full result as it will stand once the last nibble is written.
  always_comb begin
    d_upd        = d_q;
    d_upd[idx_q] = nib_d;
    d_fin        = d_upd;
`ifdef NIBBLE_SUB_SAT_EN
    if (nib_bout) begin
      d_fin = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            idx_q   <= '0;
            br_q    <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          br_q  <= nib_bout;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            d_q      <= d_fin;
            borrow_q <= nib_bout;
            zero_q   <= (d_fin == '0);
            state_q  <= DONE;
          end else begin
            d_q <= d_upd;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign D      = d_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Randomised self-checking bench for nibble_serial_subtractor against an arithmetic model.
module tb_nibble_serial_subtractor;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset, enable, start;
  logic [W-1:0] a, b, d;
  logic         busy, done, borrow, zero;

  int checks = 0;
  int errors = 0;

  nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .start  (start),
    .A      (a),
    .B      (b),
    .busy   (busy),
    .done   (done),
    .D      (d),
    .borrow (borrow),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] dd, output logic bb, output logic zz);
    bb = (x < y);
    dd = W'(x - y);
`ifdef NIBBLE_SUB_SAT_EN
    if (bb) dd = '0;
`endif
    zz = (dd == '0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requires IDLE with enable high; the start is accepted at the edge inside.
  task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts edges until done; -1 if the budget runs out.
  task automatic wait_done(input bit rand_stall, output int n);
    n = 0;
    while (!done && n < 100) begin
      if (rand_stall) enable = ($urandom_range(3) != 0);
      step();
      n++;
    end
    enable = 1'b1;
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; start = 1'b0; a = '0; b = '0;
    step();
    step();
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (d !== '0)        begin errors++; $display("FAIL reset_d got %h want 0", d); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow); end
    checks++; if (zero !== 1'b0)   begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [W-1:0] xs [4] = '{16'h1234, 16'h0000, 16'hA5A5, 16'h1000};
    logic [W-1:0] ys [4] = '{16'h0234, 16'h0001, 16'hA5A5, 16'h0001};
    logic [W-1:0] ed;
    logic eb, ez;
    int n;
    for (int i = 0; i < 4; i++) begin
      model(xs[i], ys[i], ed, eb, ez);
      do_start(xs[i], ys[i]);
      wait_done(1'b0, n);
      checks++; if (n != NIBBLES) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, n, NIBBLES); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got %b want 1", i, busy); end
      checks++; if (d !== ed)      begin errors++; $display("FAIL dir%0d_d got %h want %h", i, d, ed); end
      checks++; if (borrow !== eb) begin errors++; $display("FAIL dir%0d_borrow got %b want %b", i, borrow, eb); end
      checks++; if (zero !== ez)   begin errors++; $display("FAIL dir%0d_zero got %b want %b", i, zero, ez); end
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL dir%0d_idle got done=%b busy=%b want 0 0", i, done, busy);
      end
      checks++; if (d !== ed)      begin errors++; $display("FAIL dir%0d_hold got %h want %h", i, d, ed); end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] ed, sd;
    logic eb, ez;
    int n;
    model(16'h1234, 16'h0234, ed, eb, ez);
    do_start(16'h1234, 16'h0234);
    step();
    sd = d;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (d !== sd || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL stall_freeze%0d got d=%h busy=%b done=%b want %h 1 0", i, d, busy, done, sd);
      end
    end
    enable = 1'b1;
    wait_done(1'b0, n);
    checks++; if (n + 4 != NIBBLES + 3) begin
      errors++; $display("FAIL stall_latency got %0d want %0d", n + 4, NIBBLES + 3);
    end
    checks++; if (d !== ed) begin errors++; $display("FAIL stall_d got %h want %h", d, ed); end
    enable = 1'b0;
    step();
    step();
    checks++; if (done !== 1'b1 || d !== ed) begin
      errors++; $display("FAIL frozen_done got done=%b d=%h want 1 %h", done, d, ed);
    end
    enable = 1'b1;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", done); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x, y, ed;
    logic eb, ez;
    int n, pulses;
    do_start(16'hBEEF, 16'h1234);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state got busy=%b done=%b want 0 0", busy, done);
    end
    checks++; if (d !== '0 || borrow !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outs got d=%h b=%b z=%b want 0 0 0", d, borrow, zero);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL mid_reset_nodone got %0d want 0", pulses); end
    x = W'($urandom);
    y = W'($urandom);
    model(x, y, ed, eb, ez);
    do_start(x, y);
    wait_done(1'b0, n);
    checks++; if (d !== ed || borrow !== eb) begin
      errors++; $display("FAIL mid_reset_fresh got d=%h b=%b want %h %b", d, borrow, ed, eb);
    end
    step();
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] x, y, ed, cd;
    logic eb, ez;
    int pulses;
    x = 16'h8421;
    y = 16'h1357;
    model(x, y, ed, eb, ez);
    do_start(x, y);
    step();
    a = 16'h0F0F;
    b = 16'hF0F0;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    pulses = 0;
    cd = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) begin
        pulses++;
        cd = d;
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    checks++; if (cd !== ed)   begin errors++; $display("FAIL ignore_d got %h want %h", cd, ed); end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, ed;
    logic eb, ez;
    int n;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      case ($urandom_range(5))
        0: y = x;
        1: x = '0;
        2: y = x + W'(1);
        default: ;
      endcase
      model(x, y, ed, eb, ez);
      do_start(x, y);
      wait_done(1'b1, n);
      checks++; if (n < 0) begin errors++; $display("FAIL rnd%0d_timeout got %0d want >=0", i, n); end
      checks++; if (d !== ed || borrow !== eb || zero !== ez) begin
        errors++;
        $display("FAIL rnd%0d %h-%h got d=%h b=%b z=%b want %h %b %b", i, x, y, d, borrow, zero,
                 ed, eb, ez);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
